// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bring-up fabric: bus widths, slave
// base addresses and the command-master state encoding.
package wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_ADR_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_ADR_W-1:0] SRAM_BASE       = 32'h0000_0000;
  localparam logic [WB_ADR_W-1:0] WB2BYTEOUT_BASE = 32'h0002_0300;
  localparam logic [WB_ADR_W-1:0] WB2BYTEIO_BASE  = 32'h0002_0380;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_BUS  = BUS,
    ST_RESP = RESP
  } state_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone signals of wb_cmd_master.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// the offering side holds valid and payload stable until that edge.
interface wb_cmd_master_if;
  import wb_pkg::*;

  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic                i_cmd_we;
  logic [WB_SEL_W-1:0] i_cmd_sel;
  logic [WB_ADR_W-1:0] i_cmd_adr;
  logic [WB_DAT_W-1:0] i_cmd_dat;

  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [WB_DAT_W-1:0] o_rsp_dat;
  logic                o_rsp_we;
  logic                o_rsp_err;

  logic                o_wbm_cyc;
  logic                o_wbm_stb;
  logic                o_wbm_we;
  logic [WB_SEL_W-1:0] o_wbm_sel;
  logic [WB_ADR_W-1:0] o_wbm_adr;
  logic [WB_DAT_W-1:0] o_wbm_dat;
  logic                i_wbs_ack;
  logic [WB_DAT_W-1:0] i_wbs_dat;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_sel, i_cmd_adr, i_cmd_dat,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_dat, o_rsp_we, o_rsp_err,
    input  i_rsp_ready,
    output o_wbm_cyc, o_wbm_stb, o_wbm_we, o_wbm_sel, o_wbm_adr, o_wbm_dat,
    input  i_wbs_ack, i_wbs_dat
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_sel, i_cmd_adr, i_cmd_dat,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_dat, o_rsp_we, o_rsp_err,
    output i_rsp_ready,
    input  o_wbm_cyc, o_wbm_stb, o_wbm_we, o_wbm_sel, o_wbm_adr, o_wbm_dat,
    output i_wbs_ack, i_wbs_dat
  );

endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: accepts one command, runs one
// cyc/stb cycle until ack or timeout, then returns a response.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  wb_cmd_master_if.master      bus,
  output logic                 o_busy,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output state_t               o_state
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic [WB_ADR_W-1:0]   adr_q, adr_d;
  logic [WB_DAT_W-1:0]   dat_q, dat_d;
  logic [WB_DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                  rsp_we_q, rsp_we_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  timeout_hit;

  // TIMEOUT == 0 disables the abort path; the counter then just wraps.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_we_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_we_q  <= rsp_we_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_we_d  = rsp_we_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          we_d    = bus.i_cmd_we;
          sel_d   = bus.i_cmd_sel;
          adr_d   = bus.i_cmd_adr;
          dat_d   = bus.i_cmd_we ? bus.i_cmd_dat : '0;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a timeout landing on the same edge.
        if (bus.i_wbs_ack) begin
          cyc_d     = 1'b0;
          dat_d     = '0;
          rsp_dat_d = we_q ? '0 : bus.i_wbs_dat;
          rsp_we_d  = we_q;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else if (timeout_hit) begin
          cyc_d     = 1'b0;
          dat_d     = '0;
          rsp_dat_d = '0;
          rsp_we_d  = we_q;
          rsp_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_cmd_ready = (state_q == ST_IDLE);
  assign bus.o_rsp_valid = (state_q == ST_RESP);
  assign bus.o_rsp_dat   = rsp_dat_q;
  assign bus.o_rsp_we    = rsp_we_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_wbm_cyc   = cyc_q;
  assign bus.o_wbm_stb   = cyc_q;
  assign bus.o_wbm_we    = we_q;
  assign bus.o_wbm_sel   = sel_q;
  assign bus.o_wbm_adr   = adr_q;
  assign bus.o_wbm_dat   = dat_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_err_cnt       = err_cnt_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a registered-ack behavioural slave
// standing in for the SRAM and wb2byteio targets.
module tb_wb_cmd_master;
  import wb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] err_cnt;
  state_t     state;

  int checks = 0;
  int passes = 0;

  wb_cmd_master_if bus ();

  wb_cmd_master #(.TIMEOUT(16), .ERR_CNT_W(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus.master),
    .o_busy    (busy),
    .o_err_cnt (err_cnt),
    .o_state   (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [0:255];
  logic [31:0] io  [0:3];
  logic        slave_en;
  logic        spur_ack;
  logic        ack_q;
  logic [31:0] rdat_q;
  logic [7:0]  o_iobuf;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) io[i] = 32'h0;
  end

  assign o_iobuf       = io[1][7:0];
  assign bus.i_wbs_ack = ack_q | spur_ack;
  assign bus.i_wbs_dat = rdat_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      rdat_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      if (bus.o_wbm_cyc && bus.o_wbm_stb && !ack_q && slave_en) begin
        ack_q <= 1'b1;
        if (bus.o_wbm_we) begin
          rdat_q <= 32'hDEAD_BEEF;
          for (int b = 0; b < 4; b++) begin
            if (bus.o_wbm_sel[b]) begin
              if (bus.o_wbm_adr[17]) io[bus.o_wbm_adr[3:2]][8*b +: 8] <= bus.o_wbm_dat[8*b +: 8];
              else mem[bus.o_wbm_adr[9:2]][8*b +: 8] <= bus.o_wbm_dat[8*b +: 8];
            end
          end
        end else begin
          rdat_q <= bus.o_wbm_adr[17] ? io[bus.o_wbm_adr[3:2]] : mem[bus.o_wbm_adr[9:2]];
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat,
                        output logic [31:0] r_dat, output logic r_err, output logic r_we,
                        output int stb_n, output int rsp_n,
                        output logic wbm_we_seen, output logic [31:0] wbm_dat_seen);
    int t;
    bus.i_cmd_we    = we;
    bus.i_cmd_sel   = sel;
    bus.i_cmd_adr   = adr;
    bus.i_cmd_dat   = dat;
    bus.i_cmd_valid = 1'b1;
    t = 0;
    while (!bus.o_cmd_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    wbm_we_seen  = bus.o_wbm_we;
    wbm_dat_seen = bus.o_wbm_dat;
    stb_n = 0;
    while (bus.o_wbm_stb && stb_n < 100) begin
      stb_n++; @(posedge clk); #1;
    end
    rsp_n = 0;
    r_dat = bus.o_rsp_dat;
    r_err = bus.o_rsp_err;
    r_we  = bus.o_rsp_we;
    while (bus.o_rsp_valid && rsp_n < 100) begin
      rsp_n++; @(posedge clk); #1;
    end
    if (t >= 100 || stb_n >= 100 || rsp_n >= 100) begin
      checks++;
      $display("FAIL cmd_bound adr=%h: ready_wait=%0d stb=%0d rsp=%0d, required all < 100",
               adr, t, stb_n, rsp_n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (bus.o_cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", bus.o_cmd_ready);
    else passes++;
    checks++;
    if ({bus.o_rsp_valid, bus.o_wbm_cyc, bus.o_wbm_stb, bus.o_wbm_we, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.o_rsp_valid, bus.o_wbm_cyc, bus.o_wbm_stb, bus.o_wbm_we, busy});
    else passes++;
    checks++;
    if ({bus.o_wbm_adr, bus.o_wbm_dat, bus.o_rsp_dat, err_cnt} !== 104'h0)
      $display("FAIL reset_data: adr=%h dat=%h rsp=%h err_cnt=%0d want all 0",
               bus.o_wbm_adr, bus.o_wbm_dat, bus.o_rsp_dat, err_cnt);
    else passes++;
    checks++;
    if (state !== ST_IDLE) $display("FAIL reset_state: got %0d want 0", state);
    else passes++;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, wd; logic er, rw, ws; int sn, rn;
    do_cmd(1'b1, 4'b1111, 32'h0000_0004, 32'hABCD_0004, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (sn !== 2) $display("FAIL wr_stb_cycles: got %0d want 2", sn); else passes++;
    checks++;
    if (ws !== 1'b1 || wd !== 32'hABCD_0004)
      $display("FAIL wr_wbm: we=%b dat=%h want we=1 dat=abcd0004", ws, wd);
    else passes++;
    checks++;
    if (rn !== 1 || er !== 1'b0 || rd !== 32'h0 || rw !== 1'b1)
      $display("FAIL wr_rsp: n=%0d err=%b dat=%h we=%b want 1/0/0/1", rn, er, rd, rw);
    else passes++;
    do_cmd(1'b0, 4'b1111, 32'h0000_0004, 32'h5555_5555, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (ws !== 1'b0 || wd !== 32'h0) $display("FAIL rd_wbm: we=%b dat=%h want 0/0", ws, wd);
    else passes++;
    checks++;
    if (rd !== 32'hABCD_0004 || er !== 1'b0 || rw !== 1'b0 || sn !== 2)
      $display("FAIL rd_rsp: dat=%h err=%b we=%b stb=%0d want abcd0004/0/0/2", rd, er, rw, sn);
    else passes++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, wd; logic er, rw, ws; int sn, rn;
    do_cmd(1'b1, 4'b1111, 32'h0000_0000, 32'hABCD_0000, rd, er, rw, sn, rn, ws, wd);
    do_cmd(1'b1, 4'b1001, 32'h0000_0000, 32'hFFFF_FFFF, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (bus.o_wbm_sel !== 4'b1001) $display("FAIL be_sel_hold: got %b want 1001", bus.o_wbm_sel);
    else passes++;
    do_cmd(1'b0, 4'b1111, 32'h0000_0000, 32'h0, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (rd !== 32'hFFCD_00FF) $display("FAIL be_read: got %h want ffcd00ff", rd);
    else passes++;
  endtask

  task automatic test_byteio();
    logic [31:0] rd, wd; logic er, rw, ws; int sn, rn;
    do_cmd(1'b1, 4'b1111, 32'h0002_0388, 32'h0, rd, er, rw, sn, rn, ws, wd);
    do_cmd(1'b1, 4'b1111, 32'h0002_0384, 32'h0000_00AB, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (o_iobuf !== 8'hAB) $display("FAIL io_iobuf: got %h want ab", o_iobuf); else passes++;
    checks++;
    if (bus.o_wbm_adr !== 32'h0002_0384 || bus.o_wbm_we !== 1'b1 || bus.o_wbm_dat !== 32'h0)
      $display("FAIL io_hold: adr=%h we=%b dat=%h want 00020384/1/0",
               bus.o_wbm_adr, bus.o_wbm_we, bus.o_wbm_dat);
    else passes++;
    do_cmd(1'b0, 4'b1111, 32'h0002_0384, 32'h0, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (rd !== 32'h0000_00AB) $display("FAIL io_read: got %h want 000000ab", rd); else passes++;
  endtask

  task automatic test_timeout();
    logic [31:0] rd, wd; logic er, rw, ws; int sn, rn;
    slave_en = 1'b0;
    do_cmd(1'b0, 4'b1111, 32'h0000_0004, 32'h0, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (sn !== 16) $display("FAIL to_stb_cycles: got %0d want 16", sn); else passes++;
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || rn !== 1)
      $display("FAIL to_rsp: err=%b dat=%h n=%0d want 1/0/1", er, rd, rn);
    else passes++;
    checks++;
    if (err_cnt !== 8'd1) $display("FAIL to_cnt1: got %0d want 1", err_cnt); else passes++;
    for (int i = 1; i < 300; i++)
      do_cmd(1'b1, 4'b0001, 32'h0000_0008, 32'h1, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (err_cnt !== 8'd255) $display("FAIL to_saturate: got %0d want 255", err_cnt);
    else passes++;
    checks++;
    if (er !== 1'b1 || rw !== 1'b1) $display("FAIL to_wr_rsp: err=%b we=%b want 1/1", er, rw);
    else passes++;
    slave_en = 1'b1;
  endtask

  task automatic test_backpressure();
    int t;
    bus.i_rsp_ready = 1'b0;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_sel   = 4'b1111;
    bus.i_cmd_adr   = 32'h0000_0004;
    bus.i_cmd_dat   = 32'h0;
    bus.i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_adr = 32'h0000_0008;
    t = 0;
    while (bus.o_wbm_stb && t < 100) begin
      @(posedge clk); #1; t++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_dat !== 32'hABCD_0004 ||
          bus.o_cmd_ready !== 1'b0 || bus.o_wbm_stb !== 1'b0)
        $display("FAIL bp_hold[%0d]: rv=%b dat=%h rdy=%b stb=%b want 1/abcd0004/0/0",
                 i, bus.o_rsp_valid, bus.o_rsp_dat, bus.o_cmd_ready, bus.o_wbm_stb);
      else passes++;
      @(posedge clk); #1;
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_cmd_ready !== 1'b1)
      $display("FAIL bp_release: rv=%b rdy=%b want 0/1", bus.o_rsp_valid, bus.o_cmd_ready);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (bus.o_wbm_stb !== 1'b0 || bus.o_wbm_adr !== 32'h0000_0004)
      $display("FAIL bp_no_accept: stb=%b adr=%h want 0/00000004", bus.o_wbm_stb, bus.o_wbm_adr);
    else passes++;
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.o_rsp_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL spurious_ack[%0d]: rv=%b busy=%b want 0/0", i, bus.o_rsp_valid, busy);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_bus();
    logic [31:0] rd, wd; logic er, rw, ws; int sn, rn; int seen;
    slave_en        = 1'b0;
    bus.i_cmd_we    = 1'b1;
    bus.i_cmd_sel   = 4'b1111;
    bus.i_cmd_adr   = 32'h0000_000C;
    bus.i_cmd_dat   = 32'h1234_5678;
    bus.i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.o_wbm_stb !== 1'b1) $display("FAIL rst_pre_stb: got %b want 1", bus.o_wbm_stb);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_wbm_cyc !== 1'b0 || bus.o_wbm_stb !== 1'b0 || bus.o_rsp_valid !== 1'b0 ||
        bus.o_cmd_ready !== 1'b1 || err_cnt !== 8'd0)
      $display("FAIL rst_async: cyc=%b stb=%b rv=%b rdy=%b err_cnt=%0d want 0/0/0/1/0",
               bus.o_wbm_cyc, bus.o_wbm_stb, bus.o_rsp_valid, bus.o_cmd_ready, err_cnt);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    slave_en = 1'b1;
    seen = 0;
    repeat (20) begin
      if (bus.o_rsp_valid || bus.o_wbm_stb) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) $display("FAIL rst_no_rsp: activity cycles %0d want 0", seen); else passes++;
    do_cmd(1'b1, 4'b1111, 32'h0000_000C, 32'h1234_5678, rd, er, rw, sn, rn, ws, wd);
    do_cmd(1'b0, 4'b1111, 32'h0000_000C, 32'h0, rd, er, rw, sn, rn, ws, wd);
    checks++;
    if (rd !== 32'h1234_5678 || er !== 1'b0 || sn !== 2)
      $display("FAIL rst_after: dat=%h err=%b stb=%0d want 12345678/0/2", rd, er, sn);
    else passes++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n           = 1'b0;
    slave_en        = 1'b1;
    spur_ack        = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_sel   = 4'b0;
    bus.i_cmd_adr   = 32'h0;
    bus.i_cmd_dat   = 32'h0;
    bus.i_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_write_read();
    test_byte_enable();
    test_byteio();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
